day10_min_press_solver: RTL and testbench
=========================================

// Module: day10_min_press_solver
// PURPOSE
//  Consumer stage directly downstream of the day-10 input reader. Per machine: requests a record,
//  latches target mask + button masks, brute-forces all button subsets in Gray-code order (one
//  XOR per cycle), finds min presses reaching target, accumulates the sum over all machines.
//  Repeats until reader reports end of input, then reports final total.
// PARAMETERS
//  MAX_NUM_LIGHTS     10   max lights per machine (width of target/button masks)
//  MAX_NUM_BUTTONS    13   max buttons per machine; search space 2^MAX_NUM_BUTTONS
//  MAX_NUM_BUTTONS_W  clog2(MAX_NUM_BUTTONS+1)  width of button counts/popcount
//  TOTAL_W            32   width of accumulated total
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     reset: synchronous, active-low
//  start            in   1     pulse: clear total, begin processing input stream
//  reader_start     out  1     1-cycle request to reader for next machine record
//  reader_ready     in   1     1-cycle pulse from reader: day10_input fields valid this cycle
//  end_of_input     in   1     sticky flag from reader: last record has been read
//  day10_input      if   -     day10_input_if.consumer: num_lights, num_buttons, target, buttons[]
//  machine_valid    out  1     1-cycle pulse: per-machine result valid
//  machine_presses  out  MAX_NUM_BUTTONS_W  min presses for the machine just solved
//  machine_no_sol   out  1     qualifies machine_valid: target unreachable
//  total            out  TOTAL_W  running sum of machine_presses (solvable machines only)
//  busy / done      out  1     processing in progress / final total valid (held)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; total 0. Reset mid-operation aborts immediately, no result.
//  States: IDLE -> REQUEST -> WAIT_INPUT -> SEARCH -> ACCUM -> (REQUEST | DONE).
//  IDLE: on start go REQUEST, total<=0, done<=0. start ignored in all states except IDLE/DONE.
//  REQUEST: reader_start=1 for exactly this cycle; next WAIT_INPUT.
//  WAIT_INPUT: on reader_ready latch num_buttons, target, buttons[0..MAX-1] into local regs;
//   init cur=0, pc=0, k=0, best=all-ones sentinel; next SEARCH. Inputs not sampled afterwards.
//  SEARCH: cycle k (k=0..2^num_buttons-1): if k>0, j=ctz(k); cur^=buttons[j];
//   pc += gray(k)[j] ? +1 : -1. Compare with updated cur/pc: if cur==target, best=min(best,pc).
//   At k==2^num_buttons-1 next ACCUM. Exactly 2^num_buttons SEARCH cycles; buttons with index
//   >= num_buttons never touched. num_buttons=0 -> single cycle (k=0, empty subset).
//  ACCUM (1 cycle): machine_valid=1; machine_presses=best, or 0 with machine_no_sol=1 if best
//   is sentinel; total+=best only when solvable (zero-extended, wraps modulo 2^TOTAL_W).
//   Next DONE if end_of_input else REQUEST.
//  DONE: done=1, busy=0, total held until next start (start -> clears, goes REQUEST).
//  busy=1 in REQUEST..ACCUM. Latency reader_ready -> machine_valid = 2^num_buttons + 1 cycles.
//  reader_ready outside WAIT_INPUT ignored. num_lights unused except as documentation.
//  Light i = bit i of all masks.
// TESTING
//  1 target 4'b0110, buttons {1000,1010,0100,1100,0101,0011} -> machine_presses=2, no_sol=0.
//  2 AoC example, 3 machines -> presses 2,3,2; done=1 with total=7; 3 reader_start pulses.
//  3 target 3'b001, buttons {010,100} -> machine_no_sol=1, presses=0, total unchanged.
//  4 target 0, 5 buttons -> presses=0; machine_valid exactly 33 cycles after reader_ready.
//  5 rst_n low mid-SEARCH -> next cycle all outputs 0, IDLE; no machine_valid; start restarts.
//  6 start pulsed while busy -> ignored, total/result unaffected; start in DONE clears total.

Source files
------------

// File: rtl/day10_min_press_solver_if.sv
// Record fields handed from the day-10 input reader to its consumer.
// Sampled only while the consumer is waiting and reader_ready pulses.
interface day10_input_if #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
    parameter int NUM_LIGHTS_W      = $clog2(MAX_NUM_LIGHTS + 1)
);
    logic [NUM_LIGHTS_W-1:0]      num_lights;
    logic [MAX_NUM_BUTTONS_W-1:0] num_buttons;
    logic [MAX_NUM_LIGHTS-1:0]    target;
    logic [MAX_NUM_LIGHTS-1:0]    buttons [MAX_NUM_BUTTONS];

    modport master   (output num_lights, num_buttons, target, buttons);
    modport slave    (input  num_lights, num_buttons, target, buttons);
    modport producer (output num_lights, num_buttons, target, buttons);
    modport consumer (input  num_lights, num_buttons, target, buttons);
endinterface

// File: rtl/day10_min_press_solver.sv
// Per machine: fetch a record, walk all button subsets in Gray-code order (one XOR per cycle),
// keep the minimum press count that reaches the target, and sum it over the input stream.
module day10_min_press_solver #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
    parameter int TOTAL_W           = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         reader_start,
    input  logic                         reader_ready,
    input  logic                         end_of_input,
    day10_input_if.consumer              day10_input,
    output logic                         machine_valid,
    output logic [MAX_NUM_BUTTONS_W-1:0] machine_presses,
    output logic                         machine_no_sol,
    output logic [TOTAL_W-1:0]           total,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   dbg_state
);
    localparam int KW = MAX_NUM_BUTTONS + 1;
    localparam logic [MAX_NUM_BUTTONS_W-1:0] NO_SOL = '1;

    // Handshake: reader_start is a one-cycle request issued from REQUEST; the reader answers
    // with a one-cycle reader_ready, and record fields are captured only in that cycle while in
    // WAIT_INPUT. reader_ready in any other state is ignored.
    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_WAIT_INPUT, S_SEARCH, S_ACCUM, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [MAX_NUM_BUTTONS_W-1:0] nb;
    logic [MAX_NUM_LIGHTS-1:0]    tgt;
    logic [MAX_NUM_LIGHTS-1:0]    btn [MAX_NUM_BUTTONS];
    logic [MAX_NUM_LIGHTS-1:0]    cur;
    logic [MAX_NUM_BUTTONS_W-1:0] pc;
    logic [MAX_NUM_BUTTONS_W-1:0] best;
    logic [MAX_NUM_BUTTONS-1:0]   k;

    logic [KW-1:0]                k_span;
    logic                         last_k;
    logic [MAX_NUM_BUTTONS_W-1:0] j;
    logic [MAX_NUM_BUTTONS-1:0]   gray;
    logic [MAX_NUM_LIGHTS-1:0]    step_cur;
    logic [MAX_NUM_BUTTONS_W-1:0] step_pc;
    logic [MAX_NUM_BUTTONS_W-1:0] best_nxt;
    logic                         unused_num_lights;

    assign unused_num_lights = ^day10_input.num_lights;

    function automatic logic [MAX_NUM_BUTTONS_W-1:0] ctz(input logic [MAX_NUM_BUTTONS-1:0] v);
        ctz = '0;
        for (int i = MAX_NUM_BUTTONS - 1; i >= 0; i--)
            if (v[i]) ctz = i[MAX_NUM_BUTTONS_W-1:0];
    endfunction

    // Step k flips button ctz(k); its new Gray bit says whether it was pressed or released.
    assign k_span   = (KW'(1) << nb) - KW'(1);
    assign last_k   = ({1'b0, k} == k_span);
    assign j        = ctz(k);
    assign gray     = k ^ (k >> 1);
    assign step_cur = (k == '0) ? cur : (cur ^ btn[j]);
    assign step_pc  = (k == '0) ? pc : (gray[j] ? pc + MAX_NUM_BUTTONS_W'(1)
                                                : pc - MAX_NUM_BUTTONS_W'(1));
    assign best_nxt = ((step_cur == tgt) && (step_pc < best)) ? step_pc : best;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        reader_start    = 1'b0;
        machine_valid   = 1'b0;
        machine_presses = '0;
        machine_no_sol  = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state)
            S_IDLE:       if (start) state_nxt = S_REQUEST;
            S_REQUEST: begin
                busy         = 1'b1;
                reader_start = 1'b1;
                state_nxt    = S_WAIT_INPUT;
            end
            S_WAIT_INPUT: begin
                busy = 1'b1;
                if (reader_ready) state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
                busy = 1'b1;
                if (last_k) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                busy            = 1'b1;
                machine_valid   = 1'b1;
                machine_no_sol  = (best == NO_SOL);
                machine_presses = (best == NO_SOL) ? '0 : best;
                state_nxt       = end_of_input ? S_DONE : S_REQUEST;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_REQUEST;
            end
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nb    <= '0;
            tgt   <= '0;
            cur   <= '0;
            pc    <= '0;
            best  <= NO_SOL;
            k     <= '0;
            total <= '0;
            for (int i = 0; i < MAX_NUM_BUTTONS; i++) btn[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) total <= '0;
                S_WAIT_INPUT: if (reader_ready) begin
                    nb   <= day10_input.num_buttons;
                    tgt  <= day10_input.target;
                    for (int i = 0; i < MAX_NUM_BUTTONS; i++) btn[i] <= day10_input.buttons[i];
                    cur  <= '0;
                    pc   <= '0;
                    k    <= '0;
                    best <= NO_SOL;
                end
                S_SEARCH: begin
                    cur  <= step_cur;
                    pc   <= step_pc;
                    best <= best_nxt;
                    k    <= k + MAX_NUM_BUTTONS'(1);
                end
                S_ACCUM: if (best != NO_SOL) total <= total + TOTAL_W'(best);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_day10_min_press_solver.sv
// Bench for day10_min_press_solver: directed record table, mid-search reset, and random
// machines checked against a brute-force subset-enumeration model.
module tb_day10_min_press_solver;
    typedef struct packed {
        logic [3:0]       nb;
        logic [9:0]       target;
        logic [12:0][9:0] btn;
        logic [3:0]       exp_presses;
        logic             exp_no_sol;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, start, reader_ready, end_of_input;
    logic        reader_start, machine_valid, machine_no_sol, busy, done;
    logic [3:0]  machine_presses;
    logic [31:0] total;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int rs_count = 0;
    int mv_count = 0;
    vec_t tbl [5];
    vec_t stream_q [$];
    logic [4:0] exp_q [$];

    day10_input_if din ();

    day10_min_press_solver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reader_start(reader_start),
        .reader_ready(reader_ready), .end_of_input(end_of_input), .day10_input(din),
        .machine_valid(machine_valid), .machine_presses(machine_presses),
        .machine_no_sol(machine_no_sol), .total(total), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reader_start)  rs_count++;
        if (machine_valid) mv_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Button list in the concatenation is written highest index first.
    function automatic vec_t mk(input int nb, input logic [9:0] t, input logic [59:0] b,
                                input int ep, input bit ens);
        vec_t v;
        v.nb = nb[3:0];
        v.target = t;
        v.btn = 130'(b);
        v.exp_presses = ep[3:0];
        v.exp_no_sol = ens;
        return v;
    endfunction

    // Reference: try every subset directly and keep the smallest popcount that hits the target.
    function automatic logic [4:0] ref_solve(input vec_t v);
        int best = -1;
        for (int s = 0; s < (1 << v.nb); s++) begin
            logic [9:0] acc = '0;
            int cnt = 0;
            for (int b = 0; b < int'(v.nb); b++)
                if (s[b]) begin
                    acc ^= v.btn[b];
                    cnt++;
                end
            if (acc == v.target && (best < 0 || cnt < best)) best = cnt;
        end
        return (best < 0) ? 5'b00001 : {best[3:0], 1'b0};
    endfunction

    task automatic scramble_fields();
        din.target = 10'($urandom);
        din.num_buttons = 4'($urandom);
        for (int i = 0; i < 13; i++) din.buttons[i] = 10'($urandom);
    endtask

    task automatic wait_req(output bit ok);
        int w = 0;
        while (!reader_start && w < 20) begin
            step();
            w++;
        end
        ok = reader_start;
        check("req_seen", {31'd0, reader_start}, 1);
    endtask

    task automatic present(input vec_t v, input bit last);
        step();
        repeat ($urandom_range(0, 2)) step();
        din.num_lights = 4'd10;
        din.num_buttons = v.nb;
        din.target = v.target;
        for (int i = 0; i < 13; i++) din.buttons[i] = v.btn[i];
        end_of_input = last;
        reader_ready = 1'b1;
        step();
        reader_ready = 1'b0;
        scramble_fields();
    endtask

    task automatic run_stream(input bit poke_start);
        int n = stream_q.size();
        int rs0 = rs_count;
        logic [31:0] exp_total = '0;
        bit ok;
        end_of_input = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_clears_total", total, 0);
        check("start_clears_done", {31'd0, done}, 0);
        for (int m = 0; m < n; m++) begin
            vec_t v = stream_q[m];
            logic [4:0] e;
            int lat = 1;
            wait_req(ok);
            if (!ok) return;
            exp_q.push_back({v.exp_presses, v.exp_no_sol});
            present(v, m == n - 1);
            while (!machine_valid && lat < 9000) begin
                start = (poke_start && lat == 3);
                step();
                lat++;
            end
            start = 1'b0;
            check("valid_seen", {31'd0, machine_valid}, 1);
            if (!machine_valid) return;
            e = exp_q.pop_front();
            check("latency", lat, (1 << v.nb) + 1);
            check("presses", {28'd0, machine_presses}, {28'd0, e[4:1]});
            check("no_sol", {31'd0, machine_no_sol}, {31'd0, e[0]});
            if (!e[0]) exp_total += {28'd0, e[4:1]};
        end
        step();
        check("done", {31'd0, done}, 1);
        check("busy_in_done", {31'd0, busy}, 0);
        check("total", total, exp_total);
        check("reader_start_pulses", rs_count - rs0, n);
    endtask

    initial begin
        bit ok;
        int mv0;
        rst_n = 1'b0;
        start = 1'b0;
        reader_ready = 1'b0;
        end_of_input = 1'b0;
        din.num_lights = '0;
        scramble_fields();
        repeat (3) step();
        check("rst_valid", {31'd0, machine_valid}, 0);
        check("rst_presses", {28'd0, machine_presses}, 0);
        check("rst_no_sol", {31'd0, machine_no_sol}, 0);
        check("rst_total", total, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_reader_start", {31'd0, reader_start}, 0);
        rst_n = 1'b1;
        step();

        tbl[0] = mk(6, 10'b0110, {10'b0011, 10'b0101, 10'b1100, 10'b0100, 10'b1010, 10'b1000}, 2, 0);
        tbl[1] = mk(5, 10'b01000, {10'b11110, 10'b00111, 10'b10001, 10'b01100, 10'b11101}, 3, 0);
        tbl[2] = mk(4, 10'b101110, {10'b000110, 10'b110111, 10'b011001, 10'b011111}, 2, 0);
        tbl[3] = mk(2, 10'b001, {10'b100, 10'b010}, 0, 1);
        tbl[4] = mk(5, 10'b0, {10'h300, 10'h0c0, 10'h030, 10'h00c, 10'h003}, 0, 0);

        // Example stream: totals 7 over three machines.
        stream_q = '{tbl[0], tbl[1], tbl[2]};
        run_stream(1'b0);

        // Unsolvable machine leaves total alone; start pulses while busy are ignored.
        stream_q = '{tbl[0], tbl[3], tbl[4]};
        run_stream(1'b1);

        // Reset in the middle of a long search.
        start = 1'b1;
        step();
        start = 1'b0;
        wait_req(ok);
        if (ok) begin
            present(mk(13, 10'h3ff, 60'h0, 0, 1), 1'b1);
            repeat (10) step();
            mv0 = mv_count;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            check("midrst_busy", {31'd0, busy}, 0);
            check("midrst_done", {31'd0, done}, 0);
            check("midrst_total", total, 0);
            check("midrst_valid", {31'd0, machine_valid}, 0);
            repeat (40) step();
            check("midrst_no_result", mv_count - mv0, 0);
            check("midrst_idle", {31'd0, busy}, 0);
        end
        stream_q = '{tbl[2]};
        run_stream(1'b0);

        // Random machines against the reference model.
        for (int r = 0; r < 2; r++) begin
            stream_q = {};
            for (int m = 0; m < 6; m++) begin
                vec_t v;
                logic [4:0] e;
                logic [9:0] lm;
                lm = 10'((1 << $urandom_range(1, 10)) - 1);
                v.nb = 4'($urandom_range(0, 8));
                v.target = 10'($urandom) & lm;
                for (int i = 0; i < 13; i++) v.btn[i] = 10'($urandom) & lm;
                e = ref_solve(v);
                v.exp_presses = e[4:1];
                v.exp_no_sol = e[0];
                stream_q.push_back(v);
            end
            run_stream(r == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
